// File: rtl/eth_udp_parser.sv
// Ethernet/IPv4/UDP receive parser: validates headers, forwards the UDP payload
// without the trailing FCS bytes, and keeps accepted/dropped frame counters.
module eth_udp_parser #(
    parameter logic [15:0] UDP_PORT  = 16'h1234,
    parameter int unsigned FCS_BYTES = 4
) (
    input  logic        rxClkIn,
    input  logic        rstIn,
    input  logic [7:0]  dataIn,
    input  logic        dataValidIn,
    input  logic        dataLastIn,
    output logic [7:0]  payloadOut,
    output logic        payloadValidOut,
    output logic        payloadLastOut,
    output logic        frameDropOut,
    output logic [15:0] frameCntOut,
    output logic [15:0] dropCntOut
);

    localparam int unsigned IDX_W  = 11;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 16;

    localparam logic [IDX_W-1:0] IDX_MAX      = '1;
    localparam logic [IDX_W-1:0] IDX_ETYPE_HI = IDX_W'(12);
    localparam logic [IDX_W-1:0] IDX_ETYPE_LO = IDX_W'(13);
    localparam logic [IDX_W-1:0] IDX_VER_IHL  = IDX_W'(14);
    localparam logic [IDX_W-1:0] IDX_PROTO    = IDX_W'(23);
    localparam logic [IDX_W-1:0] IDX_PORT_HI  = IDX_W'(36);
    localparam logic [IDX_W-1:0] IDX_PORT_LO  = IDX_W'(37);
    localparam logic [IDX_W-1:0] IDX_HDR_END  = IDX_W'(41);
    // First index whose acceptance releases a payload byte; a frame ending earlier has no payload.
    localparam logic [IDX_W-1:0] IDX_RUNT     = IDX_W'(42 + FCS_BYTES);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HDR     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_DROP    = 2'd3;

    logic [1:0]        state;
    logic [1:0]        stateNext;
    logic [IDX_W-1:0]  idx;
    logic [BYTE_W-1:0] candSr [FCS_BYTES];
    logic              checkFail;
    logic              dropHit;
    logic              emitHit;

    // Header field check for the byte currently on dataIn, selected by its index.
    always_comb begin
        checkFail = 1'b0;
        case (idx)
            IDX_ETYPE_HI: checkFail = (dataIn != 8'h08);
            IDX_ETYPE_LO: checkFail = (dataIn != 8'h00);
            IDX_VER_IHL:  checkFail = (dataIn != 8'h45);
            IDX_PROTO:    checkFail = (dataIn != 8'h11);
            IDX_PORT_HI:  checkFail = (dataIn != UDP_PORT[15:8]);
            IDX_PORT_LO:  checkFail = (dataIn != UDP_PORT[7:0]);
            default:      checkFail = 1'b0;
        endcase
    end

    // Next state, drop decision (at most one per frame) and payload release.
    always_comb begin
        stateNext = state;
        dropHit   = 1'b0;
        emitHit   = 1'b0;
        if (dataValidIn) begin
            case (state)
                ST_IDLE: stateNext = ST_HDR;
                ST_HDR: begin
                    if (checkFail) begin
                        stateNext = ST_DROP;
                        dropHit   = 1'b1;
                    end else if (idx == IDX_HDR_END) begin
                        stateNext = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: emitHit = (idx >= IDX_RUNT);
                default: stateNext = state;
            endcase
            if (dataLastIn) begin
                stateNext = ST_IDLE;
                // Ending in header or before any payload byte is releasable is a runt;
                // a frame already in DROP was counted when its check failed.
                if (state == ST_IDLE || state == ST_HDR) begin
                    dropHit = 1'b1;
                end else if (state == ST_PAYLOAD && idx < IDX_RUNT) begin
                    dropHit = 1'b1;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge rxClkIn) begin
        if (!rstIn) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Byte index of the next accepted byte; restarts after the final byte, saturates at the top.
    always_ff @(posedge rxClkIn) begin
        if (!rstIn) begin
            idx <= '0;
        end else if (dataValidIn) begin
            if (dataLastIn) begin
                idx <= '0;
            end else if (idx != IDX_MAX) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Payload candidate delay line; its tail is the byte FCS_BYTES positions behind dataIn.
    always_ff @(posedge rxClkIn) begin
        if (!rstIn) begin
            for (int unsigned i = 0; i < FCS_BYTES; i++) begin
                candSr[i] <= '0;
            end
        end else if (dataValidIn && state == ST_PAYLOAD) begin
            candSr[0] <= dataIn;
            for (int unsigned i = 1; i < FCS_BYTES; i++) begin
                candSr[i] <= candSr[i-1];
            end
        end
    end

    // Registered payload stream, drop pulse and saturating counters.
    always_ff @(posedge rxClkIn) begin
        if (!rstIn) begin
            payloadOut      <= '0;
            payloadValidOut <= 1'b0;
            payloadLastOut  <= 1'b0;
            frameDropOut    <= 1'b0;
            frameCntOut     <= '0;
            dropCntOut      <= '0;
        end else begin
            payloadValidOut <= emitHit;
            payloadLastOut  <= emitHit && dataLastIn;
            payloadOut      <= emitHit ? candSr[FCS_BYTES-1] : '0;
            frameDropOut    <= dropHit;
            if (emitHit && dataLastIn && frameCntOut != CNT_MAX) begin
                frameCntOut <= frameCntOut + 1'b1;
            end
            if (dropHit && dropCntOut != CNT_MAX) begin
                dropCntOut <= dropCntOut + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eth_udp_parser.sv
// Self-checking bench for eth_udp_parser: scoreboard of expected payload bytes
// plus per-cycle drop-pulse and counter checks.
module tb_eth_udp_parser;

    logic        rxClk = 1'b0;
    logic        rstRxLcl;
    logic [7:0]  dataIn;
    logic        dataValidIn;
    logic        dataLastIn;
    logic [7:0]  payloadOut;
    logic        payloadValidOut;
    logic        payloadLastOut;
    logic        frameDropOut;
    logic [15:0] frameCntOut;
    logic [15:0] dropCntOut;

    int         passCnt = 0;
    int         totalCnt = 0;
    logic [8:0] expQ [$];
    logic [7:0] frm [$];
    logic [8:0] monExp;
    int         expFrame;
    int         expDrop;
    logic       expDropNow;
    bit         monEn;

    eth_udp_parser #(.UDP_PORT(16'h1234), .FCS_BYTES(4)) dut (
        .rxClkIn        (rxClk),
        .rstIn          (rstRxLcl),
        .dataIn         (dataIn),
        .dataValidIn    (dataValidIn),
        .dataLastIn     (dataLastIn),
        .payloadOut     (payloadOut),
        .payloadValidOut(payloadValidOut),
        .payloadLastOut (payloadLastOut),
        .frameDropOut   (frameDropOut),
        .frameCntOut    (frameCntOut),
        .dropCntOut     (dropCntOut)
    );

    always #5 rxClk = ~rxClk;

    // Scoreboard: every output byte must match the head of the expected queue.
    always @(negedge rxClk) begin
        if (monEn && payloadValidOut === 1'b1) begin
            totalCnt++;
            if (expQ.size() == 0) begin
                $display("FAIL payload_unexpected: got data=%02h last=%0b, required no output",
                         payloadOut, payloadLastOut);
            end else begin
                monExp = expQ.pop_front();
                if ({payloadLastOut, payloadOut} !== monExp) begin
                    $display("FAIL payload_byte: got last=%0b data=%02h, required last=%0b data=%02h",
                             payloadLastOut, payloadOut, monExp[8], monExp[7:0]);
                end else begin
                    passCnt++;
                end
            end
        end else if (monEn && payloadLastOut !== 1'b0) begin
            totalCnt++;
            $display("FAIL payload_last_alone: got last=%b with valid=%b, required 0",
                     payloadLastOut, payloadValidOut);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    task automatic buildFrame(input int len, input logic [15:0] etype, input logic [7:0] verIhl,
                              input logic [7:0] proto, input logic [15:0] port, input bit seqPay);
        logic [7:0] b;
        frm.delete();
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(255));
            case (i)
                12: b = etype[15:8];
                13: b = etype[7:0];
                14: b = verIhl;
                23: b = proto;
                36: b = port[15:8];
                37: b = port[7:0];
                default: if (seqPay && i >= 42 && i < len - 4) b = 8'(i - 42);
            endcase
            frm.push_back(b);
        end
    endtask

    // Drives the first nBytes of frm, checking the drop pulse every cycle.
    task automatic sendFrame(input string tag, input int nBytes, input bit good,
                             input int dropAt, input bit gaps);
        int len;
        int i;
        len = frm.size();
        i = 0;
        if (good) begin
            for (int n = 42; n + 4 < nBytes; n++) begin
                expQ.push_back({(nBytes == len && n == len - 5), frm[n]});
            end
            if (nBytes == len) expFrame++;
        end
        if (dropAt >= 0) expDrop++;
        while (i < nBytes) begin
            @(negedge rxClk);
            totalCnt++;
            if (frameDropOut !== expDropNow) begin
                $display("FAIL %s drop_pulse: got %b, required %b (before byte %0d)",
                         tag, frameDropOut, expDropNow, i);
            end else begin
                passCnt++;
            end
            if (gaps && $urandom_range(7) == 0) begin
                dataValidIn = 1'b0;
                dataLastIn  = 1'($urandom_range(1));
                dataIn      = 8'($urandom_range(255));
                expDropNow  = 1'b0;
            end else begin
                dataValidIn = 1'b1;
                dataIn      = frm[i];
                dataLastIn  = (i == len - 1);
                expDropNow  = (i == dropAt);
                i++;
            end
        end
    endtask

    // Idle cycles, then confirm payload drained and counters match the model.
    task automatic settle(input string tag);
        for (int c = 0; c < 8; c++) begin
            @(negedge rxClk);
            totalCnt++;
            if (frameDropOut !== expDropNow) begin
                $display("FAIL %s drop_pulse_tail: got %b, required %b (idle cycle %0d)",
                         tag, frameDropOut, expDropNow, c);
            end else begin
                passCnt++;
            end
            dataValidIn = 1'b0;
            dataLastIn  = 1'b0;
            expDropNow  = 1'b0;
        end
        totalCnt++;
        if (expQ.size() != 0) begin
            $display("FAIL %s payload_drain: got %0d bytes outstanding, required 0", tag, expQ.size());
            expQ.delete();
        end else begin
            passCnt++;
        end
        totalCnt++;
        if (frameCntOut !== 16'(expFrame)) begin
            $display("FAIL %s frame_cnt: got %0d, required %0d", tag, frameCntOut, expFrame);
        end else begin
            passCnt++;
        end
        totalCnt++;
        if (dropCntOut !== 16'(expDrop)) begin
            $display("FAIL %s drop_cnt: got %0d, required %0d", tag, dropCntOut, expDrop);
        end else begin
            passCnt++;
        end
    endtask

    task automatic applyReset();
        @(negedge rxClk);
        rstRxLcl    = 1'b0;
        dataValidIn = 1'b0;
        dataLastIn  = 1'b0;
        @(negedge rxClk);
        rstRxLcl   = 1'b1;
        expQ.delete();
        expFrame   = 0;
        expDrop    = 0;
        expDropNow = 1'b0;
    endtask

    task automatic test_reset();
        rstRxLcl = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge rxClk);
            dataValidIn = 1'b1;
            dataIn      = 8'($urandom_range(255));
            dataLastIn  = 1'($urandom_range(1));
        end
        @(negedge rxClk);
        totalCnt++;
        if (payloadOut !== 8'h00) $display("FAIL reset payload_out: got %02h, required 00", payloadOut);
        else passCnt++;
        totalCnt++;
        if (payloadValidOut !== 1'b0) $display("FAIL reset payload_valid: got %b, required 0", payloadValidOut);
        else passCnt++;
        totalCnt++;
        if (payloadLastOut !== 1'b0) $display("FAIL reset payload_last: got %b, required 0", payloadLastOut);
        else passCnt++;
        totalCnt++;
        if (frameDropOut !== 1'b0) $display("FAIL reset frame_drop: got %b, required 0", frameDropOut);
        else passCnt++;
        totalCnt++;
        if (frameCntOut !== 16'd0) $display("FAIL reset frame_cnt: got %0d, required 0", frameCntOut);
        else passCnt++;
        totalCnt++;
        if (dropCntOut !== 16'd0) $display("FAIL reset drop_cnt: got %0d, required 0", dropCntOut);
        else passCnt++;
        dataValidIn = 1'b0;
        dataLastIn  = 1'b0;
        rstRxLcl    = 1'b1;
        expFrame    = 0;
        expDrop     = 0;
        expDropNow  = 1'b0;
        monEn       = 1'b1;
    endtask

    task automatic test_good_frame();
        applyReset();
        buildFrame(66, 16'h0800, 8'h45, 8'h11, 16'h1234, 1'b1);
        sendFrame("good", 66, 1'b1, -1, 1'b1);
        settle("good");
    endtask

    task automatic test_bad_headers();
        logic [15:0] etT [5];
        logic [7:0]  verT [5];
        logic [7:0]  protoT [5];
        logic [15:0] portT [5];
        int          lenT [5];
        int          dropT [5];
        etT    = '{16'h86DD, 16'h0800, 16'h0800, 16'h0800, 16'h0800};
        verT   = '{8'h45, 8'h46, 8'h45, 8'h45, 8'h45};
        protoT = '{8'h11, 8'h11, 8'h06, 8'h11, 8'h06};
        portT  = '{16'h1234, 16'h1234, 16'h1234, 16'h1235, 16'h1234};
        lenT   = '{64, 64, 64, 64, 24};
        dropT  = '{12, 14, 23, 37, 23};
        for (int k = 0; k < 5; k++) begin
            applyReset();
            buildFrame(lenT[k], etT[k], verT[k], protoT[k], portT[k], 1'b0);
            sendFrame($sformatf("bad_hdr%0d", k), lenT[k], 1'b0, dropT[k], 1'b1);
            settle($sformatf("bad_hdr%0d", k));
        end
    endtask

    task automatic test_runt();
        applyReset();
        buildFrame(46, 16'h0800, 8'h45, 8'h11, 16'h1234, 1'b0);
        sendFrame("runt46", 46, 1'b0, 45, 1'b1);
        settle("runt46");
        buildFrame(42, 16'h0800, 8'h45, 8'h11, 16'h1234, 1'b0);
        sendFrame("runt42", 42, 1'b0, 41, 1'b0);
        settle("runt42");
        buildFrame(47, 16'h0800, 8'h45, 8'h11, 16'h1234, 1'b0);
        sendFrame("min47", 47, 1'b1, -1, 1'b0);
        settle("min47");
    endtask

    task automatic test_back_to_back();
        applyReset();
        buildFrame(1440, 16'h0800, 8'h45, 8'h11, 16'h1234, 1'b0);
        sendFrame("b2b_a", 1440, 1'b1, -1, 1'b1);
        buildFrame(60, 16'h0800, 8'h45, 8'h11, 16'h1234, 1'b0);
        sendFrame("b2b_b", 60, 1'b1, -1, 1'b0);
        settle("b2b");
    endtask

    task automatic test_reset_mid();
        applyReset();
        buildFrame(50, 16'h0800, 8'h45, 8'h11, 16'h1234, 1'b0);
        sendFrame("pre_rst", 50, 1'b1, -1, 1'b1);
        settle("pre_rst");
        buildFrame(100, 16'h0800, 8'h45, 8'h11, 16'h1234, 1'b0);
        sendFrame("mid_rst", 60, 1'b1, -1, 1'b0);
        @(negedge rxClk);
        rstRxLcl    = 1'b0;
        dataValidIn = 1'b0;
        dataLastIn  = 1'b0;
        @(negedge rxClk);
        totalCnt++;
        if (expQ.size() != 0) $display("FAIL mid_rst partial_payload: got %0d bytes outstanding, required 0", expQ.size());
        else passCnt++;
        totalCnt++;
        if ({payloadOut, payloadValidOut, payloadLastOut, frameDropOut} !== 11'd0)
            $display("FAIL mid_rst outputs: got data=%02h valid=%b last=%b drop=%b, required all 0",
                     payloadOut, payloadValidOut, payloadLastOut, frameDropOut);
        else passCnt++;
        totalCnt++;
        if ({frameCntOut, dropCntOut} !== 32'd0)
            $display("FAIL mid_rst counters: got frame=%0d drop=%0d, required 0 and 0", frameCntOut, dropCntOut);
        else passCnt++;
        rstRxLcl = 1'b1;
        expQ.delete();
        expFrame   = 0;
        expDrop    = 0;
        expDropNow = 1'b0;
        buildFrame(66, 16'h0800, 8'h45, 8'h11, 16'h1234, 1'b1);
        sendFrame("post_rst", 66, 1'b1, -1, 1'b0);
        settle("post_rst");
    endtask

    initial begin
        rstRxLcl    = 1'b0;
        dataValidIn = 1'b0;
        dataLastIn  = 1'b0;
        dataIn      = 8'h00;
        monEn       = 1'b0;
        expFrame    = 0;
        expDrop     = 0;
        expDropNow  = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_headers();
        test_runt();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/eth_udp_parser.md
ETH_UDP_PARSER -- requirements
Module: eth_udp_parser

Interface
REQ-001 SHALL have parameter UDP_PORT, default 16'h1234, UDP destination port to accept.
REQ-002 SHALL have parameter FCS_BYTES, default 4, count of trailing frame bytes stripped from the payload.
REQ-003 SHALL have port rxClkIn, input, 1, the single clock: local RX clock shared with rgmii_rx.
REQ-004 SHALL have port rstIn, input, 1, the reset: synchronous and active-low.
REQ-005 SHALL have port dataIn, input, 8, frame byte from rgmii_rx; preamble/SFD already removed, byte 0 = first destination-MAC byte.
REQ-006 SHALL have port dataValidIn, input, 1, dataIn qualifier.
REQ-007 SHALL have port dataLastIn, input, 1, final frame byte (the FCS byte); meaningful only with dataValidIn.
REQ-008 SHALL have port payloadOut, output, 8, UDP payload byte.
REQ-009 SHALL have port payloadValidOut, output, 1, payloadOut qualifier.
REQ-010 SHALL have port payloadLastOut, output, 1, final payload byte.
REQ-011 SHALL have port frameDropOut, output, 1, one-cycle pulse on a rejected frame.
REQ-012 SHALL have port frameCntOut, output, 16, accepted-frame count, saturating.
REQ-013 SHALL have port dropCntOut, output, 16, dropped-frame count, saturating.

Function
REQ-014 SHALL keep an 11-bit byte index idx: 0 at frame start, +1 per accepted input byte, saturating at 2047; idle cycles (valid low) SHALL leave all state unchanged.
REQ-015 SHALL implement states IDLE, HDR, PAYLOAD, DROP.
- IDLE -> HDR on a valid byte.
- HDR -> PAYLOAD when byte 41 passes all checks.
- HDR -> DROP on the first failed check.
- Any state -> IDLE on a valid byte with dataLastIn.
REQ-016 SHALL apply these header checks, in order, on the cycle the byte is accepted:
- bytes 12-13 == 16'h0800;
- byte 14 == 8'h45;
- byte 23 == 8'h11;
- bytes 36-37 == UDP_PORT, big-endian.
REQ-017 SHALL treat byte n >= 42 as a payload candidate and delay candidates through a FCS_BYTES-deep shift register.
REQ-018 SHALL, in PAYLOAD, present byte n on payloadOut with payloadValidOut=1 exactly one cycle after input byte n+FCS_BYTES is accepted, so FCS bytes are never output.
REQ-019 SHALL assert payloadLastOut with the byte output one cycle after dataLastIn is accepted; payloadValidOut SHALL otherwise be 0.
REQ-020 SHALL count a frame as accepted, incrementing frameCntOut, on the cycle payloadLastOut is asserted.
REQ-021 SHALL treat dataLastIn before idx 46 (payload < 1 byte) as a runt and drop it; a runt SHALL produce no payload output.
REQ-022 SHALL, on drop, pulse frameDropOut for one cycle:
- check failures: one cycle after the failing byte;
- runts: one cycle after dataLastIn.
It SHALL also increment dropCntOut once per frame.
REQ-023 SHALL handle a failed check and dataLastIn on the same byte as a single drop: one pulse, one increment.
REQ-024 SHALL accept back-to-back frames (dataLastIn, next byte 0 on the following cycle) with no lost byte.
REQ-025 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-026 SHALL, while rstIn=0 at a rxClkIn edge, set state IDLE, idx 0, shift register 0, and every output 0, including both counters.
REQ-027 SHALL abandon an in-progress frame on reset mid-frame, with no payloadLastOut and no drop count; the first valid byte after release SHALL be byte 0.

Verification
REQ-028 Frame of 14+20+8 headers, port 16'h1234, payload 8'h00..8'h13, 4 FCS bytes -> 20 payloadValidOut cycles 8'h00..8'h13, last on 8'h13, frameCntOut=1, no drop.
REQ-029 Ethertype 16'h86DD, 64 bytes -> no payloadValidOut, one frameDropOut pulse, dropCntOut=1.
REQ-030 UDP port 16'h1235, otherwise valid -> drop, dropCntOut=1, frameCntOut unchanged.
REQ-031 Valid headers, dataLastIn at byte 45 -> runt drop, no payload, dropCntOut=1.
REQ-032 Two valid frames back-to-back, 1440-byte and 60-byte -> payloads of 1394 and 14 bytes in order, frameCntOut=2.
REQ-033 rstIn=0 for one cycle mid-payload, then a valid frame -> outputs 0 the cycle after reset, second frame forwarded intact, frameCntOut=1.
